// File: rtl/pixel_compositor_pkg.sv
// Shared constants and helpers for the final video compositing stage.
package pixel_compositor_pkg;
  localparam int COLOR_W     = 12;
  localparam int N_ENEMY     = 6;
  localparam int ENEMY_IDX_W = $clog2(N_ENEMY);

  typedef logic [COLOR_W-1:0] rgb_t;

  localparam rgb_t BG_RGB   = 12'h69C;
  localparam rgb_t OVER_RGB = 12'h0F0;
  localparam rgb_t HIT_RGB  = 12'hFFF;

  typedef enum logic {FLASH_ON = 1'b0, FLASH_OFF = 1'b1} flash_phase_e;

  // Lowest-numbered active enemy wins when sprites overlap.
  function automatic logic [ENEMY_IDX_W-1:0] lowest_enemy(input logic [N_ENEMY-1:0] on);
    lowest_enemy = '0;
    for (int i = N_ENEMY-1; i >= 0; i--)
      if (on[i]) lowest_enemy = ENEMY_IDX_W'(i);
  endfunction
endpackage

// File: rtl/pixel_compositor_if.sv
// Layer enables and colours from the sprite/tile generators into the compositor.
interface pixel_compositor_if;
  import pixel_compositor_pkg::*;

  logic                              explosion_on;
  rgb_t                              explosion_rgb;
  logic                              bomberman_on;
  rgb_t                              bomberman_rgb;
  logic [N_ENEMY-1:0]                enemy_on;
  logic [N_ENEMY-1:0][COLOR_W-1:0]   enemy_rgb;
  logic                              bomb_on;
  rgb_t                              bomb_rgb;
  logic                              breakable_wall_on;
  rgb_t                              breakable_wall_rgb;
  logic                              unbreakable_wall_on;
  rgb_t                              unbreakable_wall_rgb;

  modport master (
    output explosion_on, explosion_rgb, bomberman_on, bomberman_rgb,
           enemy_on, enemy_rgb, bomb_on, bomb_rgb,
           breakable_wall_on, breakable_wall_rgb,
           unbreakable_wall_on, unbreakable_wall_rgb
  );
  modport slave (
    input  explosion_on, explosion_rgb, bomberman_on, bomberman_rgb,
           enemy_on, enemy_rgb, bomb_on, bomb_rgb,
           breakable_wall_on, breakable_wall_rgb,
           unbreakable_wall_on, unbreakable_wall_rgb
  );
endinterface

// File: rtl/pixel_compositor_sync_delay.sv
// Generic WIDTH x DEPTH shift register; every stage is visible on taps.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             rst_val,
  input  logic [WIDTH-1:0]             din,
  output logic [DEPTH-1:0][WIDTH-1:0]  taps
);
  logic [DEPTH-1:0][WIDTH-1:0] taps_d, taps_q;

  always_comb begin
    taps_d    = taps_q;
    taps_d[0] = din;
    for (int i = 1; i < DEPTH; i++) taps_d[i] = taps_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) taps_q <= {DEPTH{rst_val}};
    else       taps_q <= taps_d;
  end

  assign taps = taps_q;
endmodule

// File: rtl/pixel_compositor.sv
// Final video stage: layer priority resolve, game-over flash, and sync/colour
// alignment toward the VGA pins.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int PIPE_LAT     = 2,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     bright,
  input  logic                     game_over,
  pixel_compositor_if.slave        lyr,
  output logic                     hSync,
  output logic                     vSync,
  output logic [3:0]               vgaR,
  output logic [3:0]               vgaG,
  output logic [3:0]               vgaB,
  output logic                     frame_start
);
  localparam int CNT_W = 6;

  // {hsync, vsync, bright}; idle value keeps syncs deasserted and the screen dark.
  logic [PIPE_LAT-1:0][2:0] dly;
  sync_delay #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_sync_delay (
    .clk     (clk),
    .reset   (reset),
    .rst_val (3'b110),
    .din     ({hsync_in, vsync_in, bright}),
    .taps    (dly)
  );

  logic bright_s1;
  logic unused_taps;
  assign bright_s1   = dly[PIPE_LAT-2][0];
  assign hSync       = dly[PIPE_LAT-1][2];
  assign vSync       = dly[PIPE_LAT-1][1];
  assign unused_taps = ^{dly[PIPE_LAT-2][2:1], dly[PIPE_LAT-1][0]};

  rgb_t             color_d, color_q;
  rgb_t             rgb_d, rgb_q;
  logic             vsync_prev_d, vsync_prev_q;
  logic             frame_start_d, frame_start_q;
  logic             over_d, over_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  flash_phase_e     phase_d, phase_q;

  always_comb begin
    color_d = BG_RGB;
    if (lyr.explosion_on)                      color_d = lyr.explosion_rgb;
    else if (lyr.bomberman_on && lyr.bomb_on)  color_d = HIT_RGB;
    else if (lyr.bomberman_on)                 color_d = lyr.bomberman_rgb;
    else if (|lyr.enemy_on)                    color_d = lyr.enemy_rgb[lowest_enemy(lyr.enemy_on)];
    else if (lyr.bomb_on)                      color_d = lyr.bomb_rgb;
    else if (lyr.breakable_wall_on)            color_d = lyr.breakable_wall_rgb;
    else if (lyr.unbreakable_wall_on)          color_d = lyr.unbreakable_wall_rgb;
  end

  // Game-over state only moves on frame boundaries so the screen never tears.
  always_comb begin
    vsync_prev_d  = vsync_in;
    frame_start_d = vsync_prev_q & ~vsync_in;
    over_d        = over_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    if (frame_start_q) begin
      if (over_q) begin
        if (cnt_q == CNT_W'(FLASH_FRAMES-1)) begin
          cnt_d   = '0;
          phase_d = (phase_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (game_over) begin
        over_d = 1'b1;
      end
    end

    if (!bright_s1)  rgb_d = '0;
    else if (over_q) rgb_d = (phase_q == FLASH_ON) ? OVER_RGB : '0;
    else             rgb_d = color_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      color_q       <= '0;
      rgb_q         <= '0;
      vsync_prev_q  <= 1'b1;
      frame_start_q <= 1'b0;
      over_q        <= 1'b0;
      cnt_q         <= '0;
      phase_q       <= FLASH_ON;
    end else begin
      color_q       <= color_d;
      rgb_q         <= rgb_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_start_q <= frame_start_d;
      over_q        <= over_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
    end
  end

  assign vgaR        = rgb_q[11:8];
  assign vgaG        = rgb_q[7:4];
  assign vgaB        = rgb_q[3:0];
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor: priority table, random traffic against a
// frame-level reference model, game-over flash and reset sequences.
module tb_pixel_compositor;
  localparam int FLASH = 30;

  logic clk = 1'b0;
  logic reset, hsync_in, vsync_in, bright, game_over;
  logic hSync, vSync, frame_start;
  logic [3:0] vgaR, vgaG, vgaB;
  logic [11:0] rgb;
  assign rgb = {vgaR, vgaG, vgaB};

  always #5 clk = ~clk;

  pixel_compositor_if lyr();

  pixel_compositor #(.PIPE_LAT(2), .FLASH_FRAMES(FLASH)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .bright(bright), .game_over(game_over), .lyr(lyr),
    .hSync(hSync), .vSync(vSync), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .frame_start(frame_start)
  );

  typedef struct {
    logic             exp_on;  logic [11:0] exp_rgb;
    logic             bm_on;   logic [11:0] bm_rgb;
    logic [5:0]       en_on;   logic [5:0][11:0] en_rgb;
    logic             bomb_on; logic [11:0] bomb_rgb;
    logic             bw_on;   logic [11:0] bw_rgb;
    logic             uw_on;   logic [11:0] uw_rgb;
  } layers_t;

  typedef struct {
    logic exp_on, bm_on; logic [5:0] en_on; logic bomb_on, bw_on, uw_on;
    logic [11:0] exp;
  } vec_t;

  typedef struct { logic hs, vs, br; logic [11:0] col; } pix_t;

  int checks = 0;
  int errors = 0;

  layers_t cur;
  pix_t    prev_in;
  bit      m_fs, m_latched;
  int      m_frames;
  logic    m_prev_vs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_color(input layers_t l);
    if (l.exp_on) return l.exp_rgb;
    if (l.bm_on)  return l.bomb_on ? 12'hFFF : l.bm_rgb;
    for (int i = 0; i < 6; i++) if (l.en_on[i]) return l.en_rgb[i];
    if (l.bomb_on) return l.bomb_rgb;
    if (l.bw_on)   return l.bw_rgb;
    if (l.uw_on)   return l.uw_rgb;
    return 12'h69C;
  endfunction

  task automatic apply(input layers_t l);
    cur = l;
    lyr.explosion_on        = l.exp_on;  lyr.explosion_rgb        = l.exp_rgb;
    lyr.bomberman_on        = l.bm_on;   lyr.bomberman_rgb        = l.bm_rgb;
    lyr.enemy_on            = l.en_on;   lyr.enemy_rgb            = l.en_rgb;
    lyr.bomb_on             = l.bomb_on; lyr.bomb_rgb             = l.bomb_rgb;
    lyr.breakable_wall_on   = l.bw_on;   lyr.breakable_wall_rgb   = l.bw_rgb;
    lyr.unbreakable_wall_on = l.uw_on;   lyr.unbreakable_wall_rgb = l.uw_rgb;
  endtask

  // One clock: the model predicts from what was presented one clock earlier and
  // from the frame-level game-over state (frames counted since the latch set).
  task automatic tick();
    pix_t now;
    logic [11:0] e_rgb;
    logic e_hs, e_vs, e_fs;
    now = reset ? pix_t'{1'b1, 1'b1, 1'b0, 12'h000}
                : pix_t'{hsync_in, vsync_in, bright, ref_color(cur)};
    @(posedge clk);
    if (reset) begin
      e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      m_latched = 1'b0; m_frames = 0; m_prev_vs = 1'b1;
    end else begin
      e_hs = prev_in.hs;
      e_vs = prev_in.vs;
      if (!prev_in.br)    e_rgb = 12'h000;
      else if (m_latched) e_rgb = ((m_frames / FLASH) % 2 == 0) ? 12'h0F0 : 12'h000;
      else                e_rgb = prev_in.col;
      e_fs = m_prev_vs && !vsync_in;
      if (m_fs) begin
        if (m_latched)      m_frames++;
        else if (game_over) begin m_latched = 1'b1; m_frames = 0; end
      end
      m_prev_vs = vsync_in;
    end
    m_fs    = e_fs;
    prev_in = now;
    #1;
    chk("rgb",         32'(rgb),         32'(e_rgb));
    chk("hSync",       32'(hSync),       32'(e_hs));
    chk("vSync",       32'(vSync),       32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic run_frame(input int drop_go_at, output logic [11:0] mid);
    mid = 12'h000;
    for (int t = 0; t < 8; t++) begin
      vsync_in = (t >= 2);
      hsync_in = t[0];
      if (t == drop_go_at) game_over = 1'b0;
      tick();
      if (t == 5) mid = rgb;
    end
  endtask

  layers_t base, l;
  vec_t    vecs[12];
  logic [11:0] mid;

  initial begin
    base = '{default: '0};
    base.exp_rgb = 12'hF80; base.bm_rgb = 12'h00F; base.bomb_rgb = 12'hABC;
    base.bw_rgb  = 12'h321; base.uw_rgb = 12'h654;
    base.en_rgb  = {12'h456, 12'h704, 12'h123, 12'h702, 12'h701, 12'h700};

    vecs[0]  = '{1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 12'h69C};
    vecs[1]  = '{1'b1, 1'b1, 6'b000000, 1'b1, 1'b0, 1'b0, 12'hF80};
    vecs[2]  = '{1'b0, 1'b1, 6'b000000, 1'b1, 1'b0, 1'b0, 12'hFFF};
    vecs[3]  = '{1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 12'h00F};
    vecs[4]  = '{1'b0, 1'b0, 6'b101000, 1'b1, 1'b0, 1'b0, 12'h123};
    vecs[5]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 12'hABC};
    vecs[6]  = '{1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b1, 12'h321};
    vecs[7]  = '{1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1, 12'h654};
    vecs[8]  = '{1'b0, 1'b0, 6'b100000, 1'b1, 1'b0, 1'b0, 12'h456};
    vecs[9]  = '{1'b0, 1'b0, 6'b111111, 1'b0, 1'b1, 1'b0, 12'h700};
    vecs[10] = '{1'b1, 1'b1, 6'b111111, 1'b1, 1'b1, 1'b1, 12'hF80};
    vecs[11] = '{1'b0, 1'b0, 6'b010000, 1'b0, 1'b0, 1'b1, 12'h704};

    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; bright = 1'b1; game_over = 1'b0;
    apply(base);
    prev_in = '{1'b1, 1'b1, 1'b0, 12'h000};
    m_fs = 1'b0; m_latched = 1'b0; m_frames = 0; m_prev_vs = 1'b1;

    repeat (3) tick();
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_sync", 32'({hSync, vSync}), 32'h3);
    reset = 1'b0;
    tick(); tick();
    chk("bg_after_reset", 32'(rgb), 32'h69C);

    foreach (vecs[i]) begin
      l = base;
      l.exp_on = vecs[i].exp_on; l.bm_on = vecs[i].bm_on; l.en_on = vecs[i].en_on;
      l.bomb_on = vecs[i].bomb_on; l.bw_on = vecs[i].bw_on; l.uw_on = vecs[i].uw_on;
      apply(l);
      tick(); tick();
      chk($sformatf("vec%0d", i), 32'(rgb), 32'(vecs[i].exp));
    end

    for (int n = 0; n < 400; n++) begin
      l.exp_on  = ($urandom_range(0, 3) == 0);
      l.bm_on   = ($urandom_range(0, 3) == 0);
      l.en_on   = 6'($urandom & $urandom);
      l.bomb_on = $urandom_range(0, 1);
      l.bw_on   = $urandom_range(0, 1);
      l.uw_on   = $urandom_range(0, 1);
      l.exp_rgb = 12'($urandom); l.bm_rgb = 12'($urandom); l.bomb_rgb = 12'($urandom);
      l.bw_rgb  = 12'($urandom); l.uw_rgb = 12'($urandom);
      for (int e = 0; e < 6; e++) l.en_rgb[e] = 12'($urandom);
      apply(l);
      hsync_in = $urandom_range(0, 1);
      vsync_in = ($urandom_range(0, 3) != 0);
      bright   = $urandom_range(0, 1);
      tick();
    end

    // Mid-frame reset, then game-over flash on short 8-clock frames.
    bright = 1'b1; vsync_in = 1'b1;
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    l = base; l.bomb_on = 1'b1; apply(l);
    run_frame(-1, mid);
    chk("pre_game_over", 32'(mid), 32'hABC);
    for (int t = 0; t < 8; t++) begin
      vsync_in = (t >= 2); hsync_in = t[0];
      if (t == 4) game_over = 1'b1;
      tick();
    end
    chk("no_tear_before_frame", 32'(rgb), 32'hABC);
    for (int f = 0; f < 66; f++) begin
      run_frame(f == 0 ? 3 : -1, mid);
      chk($sformatf("flash_f%0d", f), 32'(mid), ((f / FLASH) % 2 == 0) ? 32'h0F0 : 32'h0);
    end

    l = base;
    l.exp_on = 1'b1; l.bm_on = 1'b1; l.en_on = 6'h3F; l.bomb_on = 1'b1; l.bw_on = 1'b1; l.uw_on = 1'b1;
    apply(l);
    bright = 1'b0; vsync_in = 1'b1;
    repeat (3) tick();
    chk("dark_overrides_all", 32'(rgb), 32'h0);

    bright = 1'b1;
    reset = 1'b1; tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("latch_cleared_by_reset", 32'(rgb), 32'hF80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Final video stage between the sprite/tile generators and the VGA pins.
- Takes per-layer enables and 12-bit colours and resolves overlaps with a fixed priority.
- Handles the game-over screen.
- Registers RGB, and delays hSync/vSync/bright by the same amount so sync and colour stay aligned at the connector.

Parameters:
- PIPE_LAT, 2, clocks from pixel inputs to registered RGB; sync/bright delay lines use the same depth (fixed at 2, exposed for the bench).
- FLASH_FRAMES, 30, frames per half-period of the game-over flash (counter width 6 bits, legal 1..63).
- BG_RGB, 12'h69C, background colour.
- OVER_RGB, 12'h0F0, game-over colour.
- HIT_RGB, 12'hFFF, colour for bomberman standing on his own bomb.
- N_ENEMY, 6, number of enemy layers.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hsync_in  in  1  from display_controller, active-low
- vsync_in  in  1  from display_controller, active-low
- bright  in  1  visible-area flag
- game_over  in  1  level, from bomberman
- bomberman_on  in  1 / bomberman_rgb  in  12
- explosion_on  in  1 / explosion_rgb  in  12
- enemy_on  in  N_ENEMY  one bit per enemy
- enemy_rgb  in  12*N_ENEMY  enemy i at [12i+11:12i]
- bomb_on  in  1 / bomb_rgb  in  12
- breakable_wall_on  in  1 / breakable_wall_rgb  in  12
- unbreakable_wall_on  in  1 / unbreakable_wall_rgb  in  12
- hSync  out  1  delayed hsync_in
- vSync  out  1  delayed vsync_in
- vgaR, vgaG, vgaB  out  4 each  registered colour
- frame_start  out  1  one-clock pulse on falling edge of vsync_in

Behaviour:
- Reset values: vgaR/G/B = 0, hSync = vSync = 1, frame_start = 0, delay lines = inactive (sync 1, bright 0), flash counter = 0, flash phase = 0, game-over latch = 0.
- Stage 1 (clock k+1): priority resolve, registered together with the delayed bright. Priority, highest first:
  1. explosion_on → explosion_rgb
  2. bomberman_on & bomb_on → HIT_RGB
  3. bomberman_on → bomberman_rgb
  4. lowest-index set bit of enemy_on → that enemy's colour
  5. bomb_on → bomb_rgb
  6. breakable_wall_on → breakable_wall_rgb
  7. unbreakable_wall_on → unbreakable_wall_rgb
  8. otherwise BG_RGB
  - Any combination of enables is legal; the result is always the highest-priority active layer. There is no default-to-background on overlap.
- Stage 2 (clock k+2): output register.
  - delayed bright = 0 → RGB = 0.
  - Else, game-over latch = 1 → flash phase 0 drives OVER_RGB, phase 1 drives 12'h000.
  - Else the stage-1 colour.
- Sync alignment: hSync, vSync and bright each pass through PIPE_LAT flops. Inputs at clock k appear at the outputs at clock k+2, identical to RGB latency.
- frame_start: registered; high for exactly one clock, one clock after the clock where vsync_in goes from 1 to 0. Not delayed to match RGB.
- Game-over latch:
  - Samples game_over only on frame_start, so the screen never tears mid-frame.
  - Clears only on reset; a deassert of game_over without reset is ignored.
  - game_over high for less than one frame but present on a frame_start clock → latched.
- Flash counter:
  - Advances only while the latch is set, on each frame_start.
  - At FLASH_FRAMES-1 it wraps to 0 and toggles the flash phase.
  - Starts at count 0, phase 0 when the latch sets.
- Reset mid-frame: all state returns to reset values on the next clk edge. Outputs blank and syncs go inactive for PIPE_LAT clocks until the delay lines refill.

Decomposition:
- Shared package: BG_RGB, OVER_RGB, HIT_RGB, 12-bit colour width, N_ENEMY. The top-level enemy start positions also move to this package.
- One sub-module, sync_delay: a generic WIDTH × DEPTH shift register with a synchronous reset value input. Used for the {hsync, vsync, bright} bundle.
- Priority resolve stays inline.

Test Plan:
- Reset held 3 clocks, then released with all enables 0 and bright = 1 → vgaR/G/B = 6/9/C exactly 2 clocks after the first pixel; during reset RGB = 0 and hSync = vSync = 1.
- explosion_on = bomberman_on = bomb_on = 1 (explosion_rgb = 12'hF80) → 12'hF80; drop explosion_on → 12'hFFF; drop bomb_on (bomberman_rgb = 12'h00F) → 12'h00F.
- enemy_on = 6'b101000 with enemy 3 = 12'h123, enemy 5 = 12'h456, bomb_on = 1 → 12'h123; enemy_on = 0 → bomb_rgb.
- Toggle hsync_in/vsync_in/bright with a random pattern → hSync/vSync/bright-gating equal the input pattern delayed exactly 2 clocks; frame_start is one clock wide, one clock after each vsync_in fall.
- game_over raised mid-frame → RGB unchanged until the next frame_start, then 12'h0F0 for 30 frames, 12'h000 for 30 frames, repeating; game_over dropped → flashing continues until reset.
- bright = 0 with every enable set and game-over latched → RGB = 0.
